// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between the CPU control path
// (fetch / LDW / STW) and a peripheral port (program loader / display DMA).
// The CPU wins by default. A peripheral that has been refused MAX_WAIT cycles
// in a row is forced through. A locked peripheral burst may keep the port for
// up to BURST_MAX consecutive grants before the CPU gets a turn.
//
// Grants are combinational from the live requests and the registered
// arbiter history, so an uncontended access issues in the same cycle.
// Read data comes back one cycle after the grant and is steered to whichever
// requester issued the read.
//
// Parameters:
//   AW        address width
//   DW        data width
//   MAX_WAIT  refused peripheral cycles before the peripheral is forced (1..15)
//   BURST_MAX longest locked peripheral run (1..15)
//
// Ports:
//   CLK, reset                      clock (rising edge), async active-high reset
//   c_req/c_we/c_addr/c_wdata       CPU request, held until c_gnt
//   c_gnt, cpu_stall                CPU grant this cycle, c_req & ~c_gnt
//   c_rvalid, c_rdata               CPU read return (one cycle after grant)
//   p_req/p_we/p_addr/p_wdata/p_lock peripheral request and burst-lock hint
//   p_gnt, p_rvalid, p_rdata        peripheral grant and read return
//   mem_en/mem_we/mem_addr/mem_wdata memory port controls (all 0 when idle)
//   mem_rdata                       memory read data, valid one cycle after read
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          CLK,
  input  logic          reset,
  // CPU side
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          cpu_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // Peripheral side
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  input  logic          p_lock,
  output logic          p_gnt,
  output logic          p_rvalid,
  output logic [DW-1:0] p_rdata,
  // Memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Arbiter history: who (if anyone) was granted in the previous cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU    = 2'd1,
    ST_PBURST = 2'd2
  } arb_state_t;

  // Read-return owner encoding.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_PERI = 2'd2;

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

  arb_state_t  state_r;
  logic [3:0]  wait_cnt_r;
  logic [3:0]  burst_cnt_r;
  logic [1:0]  rd_owner_r;

  logic        burst_hold_s;
  logic        starve_s;
  logic        c_win_s;
  logic        p_win_s;

  // Saturating 4-bit increment towards a ceiling.
  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] ceil);
    logic [3:0] res;
    if (val < ceil) begin
      res = val + 4'd1;
    end else begin
      res = ceil;
    end
    return res;
  endfunction

  // Priority conditions that can override the CPU's default priority.
  always_comb begin
    burst_hold_s = 1'b0;
    starve_s     = 1'b0;
    // A locked burst keeps the port only while it is shorter than BURST_MAX;
    // at BURST_MAX the lock is ignored for this arbitration.
    if ((state_r == ST_PBURST) && p_req && (burst_cnt_r < BURST_MAX_C)) begin
      burst_hold_s = 1'b1;
    end else begin
      burst_hold_s = 1'b0;
    end
    if ((wait_cnt_r == MAX_WAIT_C) && p_req) begin
      starve_s = 1'b1;
    end else begin
      starve_s = 1'b0;
    end
  end

  // Winner selection; reset forces both grants low without waiting for a clock.
  always_comb begin
    c_win_s = 1'b0;
    p_win_s = 1'b0;
    if (reset) begin
      c_win_s = 1'b0;
      p_win_s = 1'b0;
    end else if (burst_hold_s) begin
      p_win_s = 1'b1;
    end else if (starve_s) begin
      p_win_s = 1'b1;
    end else if (c_req) begin
      c_win_s = 1'b1;
    end else if (p_req) begin
      p_win_s = 1'b1;
    end else begin
      c_win_s = 1'b0;
      p_win_s = 1'b0;
    end
  end

  // Grant outputs and the CPU stall seen by the control FSM.
  always_comb begin
    c_gnt     = c_win_s;
    p_gnt     = p_win_s;
    cpu_stall = c_req & ~c_win_s;
  end

  // Memory port mux: the winner drives the port, an idle cycle drives zeros.
  always_comb begin
    mem_en    = c_win_s | p_win_s;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (c_win_s) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (p_win_s) begin
      mem_we    = p_we;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
    end
  end

  // Arbiter FSM with its burst/starvation counters and the read-owner record.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 4'd0;
      burst_cnt_r <= 4'd0;
      rd_owner_r  <= OWN_NONE;
    end else begin
      // Next state records the kind of grant just issued.
      if (p_win_s && p_lock) begin
        state_r <= ST_PBURST;
      end else if (c_win_s) begin
        state_r <= ST_CPU;
      end else begin
        state_r <= ST_IDLE;
      end

      // Burst length. A locked grant that follows a completed burst (the
      // CPU was not asking, so the peripheral won anyway) opens a new burst
      // at 1 instead of counting past BURST_MAX.
      if (p_win_s && p_lock) begin
        case (state_r)
          ST_PBURST: begin
            if (burst_cnt_r < BURST_MAX_C) begin
              burst_cnt_r <= burst_cnt_r + 4'd1;
            end else begin
              burst_cnt_r <= 4'd1;
            end
          end
          ST_IDLE:  burst_cnt_r <= 4'd1;
          ST_CPU:   burst_cnt_r <= 4'd1;
          default:  burst_cnt_r <= 4'd1;
        endcase
      end else begin
        burst_cnt_r <= 4'd0;
      end

      // Consecutive refused peripheral cycles, saturating at MAX_WAIT.
      if (p_win_s || !p_req) begin
        wait_cnt_r <= 4'd0;
      end else begin
        wait_cnt_r <= sat_inc(wait_cnt_r, MAX_WAIT_C);
      end

      // Remember who issued a read so next cycle's data goes to them.
      if (c_win_s && !c_we) begin
        rd_owner_r <= OWN_CPU;
      end else if (p_win_s && !p_we) begin
        rd_owner_r <= OWN_PERI;
      end else begin
        rd_owner_r <= OWN_NONE;
      end
    end
  end

  // Read return steering; the non-owner sees zero data.
  always_comb begin
    c_rvalid = 1'b0;
    p_rvalid = 1'b0;
    c_rdata  = {DW{1'b0}};
    p_rdata  = {DW{1'b0}};
    case (rd_owner_r)
      OWN_CPU: begin
        c_rvalid = 1'b1;
        c_rdata  = mem_rdata;
      end
      OWN_PERI: begin
        p_rvalid = 1'b1;
        p_rdata  = mem_rdata;
      end
      OWN_NONE: begin
        c_rvalid = 1'b0;
        p_rvalid = 1'b0;
      end
      default: begin
        c_rvalid = 1'b0;
        p_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the CPU's single-port synchronous data/instruction memory between the CPU control path (fetch, LDW, STW accesses) and a peripheral port (program loader / display DMA). The CPU has default priority; the peripheral gets an anti-starvation counter and a bounded burst lock. It sits between the CPU memory-address/data muxes and the memory block. The CPU control FSM holds its memory state while `cpu_stall` is high.

## Interface
- `AW`, 8: address width.
- `DW`, 16: data width.
- `MAX_WAIT`, 4: number of consecutive denied peripheral cycles after which the peripheral is forced to win. Range 1..15.
- `BURST_MAX`, 4: maximum consecutive peripheral grants under `p_lock`. Range 1..15.

Ports:
- `CLK` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `c_req` in 1: CPU access request. Held until granted.
- `c_we` in 1: CPU write (1) or read (0).
- `c_addr` in AW: CPU address.
- `c_wdata` in DW: CPU write data.
- `c_gnt` out 1: CPU access issued this cycle.
- `cpu_stall` out 1: equals `c_req & ~c_gnt`.
- `c_rvalid` out 1: CPU read data valid.
- `c_rdata` out DW: CPU read data.
- `p_req`, `p_we`, `p_addr`, `p_wdata`, `p_lock` in 1/1/AW/DW/1: peripheral request, write, address, data, and burst-lock hint.
- `p_gnt`, `p_rvalid` out 1; `p_rdata` out DW: peripheral grant, read valid, read data.
- `mem_en`, `mem_we` out 1; `mem_addr` out AW; `mem_wdata` out DW: memory port controls.
- `mem_rdata` in DW: memory read data, valid one cycle after a read `mem_en`.

## Operation
- One access per cycle. Grants are combinational from the current requests and the registered arbiter state. Requesters hold req/we/addr/wdata stable until their gnt is seen.
- Arbiter FSM states:
  - IDLE: no grant last cycle.
  - CPU: CPU granted last cycle.
  - PBURST: peripheral granted last cycle with `p_lock`=1.
- Winner selection, in priority order:
  1. PBURST with `p_req`=1 and `burst_cnt` < BURST_MAX → peripheral.
  2. `wait_cnt` == MAX_WAIT and `p_req` → peripheral.
  3. `c_req` → CPU.
  4. `p_req` → peripheral.
  5. Otherwise no grant.
- Next state:
  - Peripheral granted with `p_lock`=1 → PBURST.
  - CPU granted → CPU.
  - Otherwise → IDLE.
- `burst_cnt` (4 bits):
  - Set to 1 on the first locked peripheral grant.
  - Incremented on each further PBURST grant.
  - Cleared on any non-peripheral cycle or when `p_lock`=0.
- When `burst_cnt` reaches BURST_MAX, the lock is ignored for one arbitration. If `c_req`=1 the CPU wins. `wait_cnt` is not consulted for this.
- `wait_cnt` (4 bits):
  - Increments, saturating at MAX_WAIT, on each cycle with `p_req`=1 and `p_gnt`=0.
  - Cleared on `p_gnt` or when `p_req`=0.
- Memory mux: `mem_en` = `c_gnt | p_gnt`. `mem_we`, `mem_addr` and `mem_wdata` come from the winner. All are 0 when there is no grant.
- Read return:
  - Registered `rd_owner` (2 bits: none/CPU/peripheral) records the winner of a read grant.
  - Next cycle, the owner's `rvalid`=1 and its `rdata` = `mem_rdata`.
  - The non-owner's `rdata` holds 0.
  - Writes produce no `rvalid`.
- Simultaneous events: a new grant may issue in the same cycle as the previous read's `rvalid` (back-to-back reads give 1 read/cycle).

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE; `wait_cnt`, `burst_cnt` and `rd_owner` = 0.
  - `c_rvalid`, `p_rvalid` = 0; `c_rdata`, `p_rdata` = 0.
  - While `reset`=1, `c_gnt`, `p_gnt`, `mem_en` and `mem_we` are forced to 0, and `cpu_stall` = `c_req`.
- Reset mid-read: the pending `rvalid` is dropped and no data is returned.
- Grant latency: 0 cycles when uncontended. A contending peripheral waits at most MAX_WAIT+1 cycles. The CPU waits at most BURST_MAX cycles.
- Read latency: `rvalid` exactly 1 cycle after the gnt cycle.
- Write: committed at the rising edge that ends the gnt cycle.

## Test plan
- **Reset:** assert `reset` mid-cycle with `c_req`=1 → `c_gnt`=0, `mem_en`=0, `cpu_stall`=1 immediately; all rvalid 0 after release until a read is granted.
- **CPU only:** read addr 0x10 (memory holds 0x1234) → `c_gnt`=1 same cycle, `cpu_stall`=0; next cycle `c_rvalid`=1, `c_rdata`=0x1234.
- **Contention, anti-starvation:** `c_req` and `p_req` held continuously, MAX_WAIT=4 → CPU granted 4 cycles, peripheral granted cycle 5, `wait_cnt` back to 0, CPU granted cycle 6.
- **Burst lock:** `p_lock`=1, `p_req` held, `c_req` held, BURST_MAX=4, peripheral already winning → 4 consecutive `p_gnt`, then a `c_gnt`.
- **Interleaved reads:** CPU read 0x01 then peripheral read 0x02 on consecutive cycles (data 0xAAAA/0x5555) → `c_rvalid` with 0xAAAA, then `p_rvalid` with 0x5555; never both high.
- **Write then read:** peripheral writes 0xBEEF at 0x20, CPU reads 0x20 the next cycle → `c_rdata`=0xBEEF, no `p_rvalid` for the write.
